gray_convert_arbiter: RTL

Round-robin arbiter and sequencer that shares one Gray-to-binary conversion datapath among `NREQ` requesters. Each requester presents a Gray-coded word and raises a request. The arbiter grants one requester at a time, latches that requester's operand, and runs it through a parameterised Gray-to-binary core. It then returns the binary result tagged with the requester's index. The block sits between sensor/encoder front-ends producing Gray counts and the downstream binary consumers.

---
 rtl/gray_pkg.sv | 22 ++
 rtl/gray_convert_arbiter_core.sv | 14 +
 rtl/gray_convert_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared constants and helpers for the Gray-to-binary arbiter.
// Includes a width-agnostic g2b reference function.
package gray_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Zero-extended inputs convert correctly for any width up to 32.
    function automatic logic [31:0] g2b(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int k = 30; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_convert_arbiter_core.sv
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray2bin_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
        assign o_bin[k] = ^i_gray[WIDTH-1:k];
    end

endmodule

// File: rtl/gray_convert_arbiter.sv
// Round-robin arbiter sharing one Gray-to-binary converter.
// Grant, convert, and release take three clocks per request.
module gray_convert_arbiter
    import gray_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] gray_in,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      bin_out,
    output logic [IDW-1:0]        bin_id,
    output logic                  bin_valid,
    output logic                  busy
);

    logic [1:0]       r_state;
    logic [IDW-1:0]   r_ptr;
    logic [WIDTH-1:0] r_gray_q;
    logic [IDW-1:0]   r_id_q;
    logic [NREQ-1:0]  r_gnt;
    logic [WIDTH-1:0] r_bin;
    logic [IDW-1:0]   r_bin_id;
    logic             r_bin_valid;

    logic             w_any;
    logic [IDW-1:0]   w_win;
    logic [IDW-1:0]   w_idx;
    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] w_bin;
    logic [IDW-1:0]   w_ptr_nxt;

    // Search upward from the pointer for the first active request.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = r_ptr;
        for (int off = 0; off < NREQ; off++) begin
            if (!w_any && req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
            w_idx = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + IDW'(1);
        end
    end

    // Select the winner's operand and compute the next pointer.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IDW'(i)) begin
                w_sel = gray_in[i*WIDTH +: WIDTH];
            end
        end
        w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);
    end

    gray2bin_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_gray (r_gray_q),
        .o_bin  (w_bin)
    );

    // Sequencer FSM: arbitrate in IDLE, publish in CONV, retire in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gray_q    <= '0;
            r_id_q      <= '0;
            r_gnt       <= '0;
            r_bin       <= '0;
            r_bin_id    <= '0;
            r_bin_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt    <= NREQ'(1) << w_win;
                        r_gray_q <= w_sel;
                        r_id_q   <= w_win;
                        r_ptr    <= w_ptr_nxt;
                        r_state  <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_gnt       <= '0;
                    r_bin       <= w_bin;
                    r_bin_id    <= r_id_q;
                    r_bin_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    r_bin_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign bin_out   = r_bin;
    assign bin_id    = r_bin_id;
    assign bin_valid = r_bin_valid;
    assign busy      = (r_state != ST_IDLE);

endmodule
